convert8to32: RTL

CONVERT8TO32 -- requirements
Module: convert8to32

---
 rtl/convert8to32.sv | 117 +++++++++++
 1 files changed

// File: rtl/convert8to32.sv
`default_nettype none
// ============================================================================
//  Module   : convert8to32
//  Purpose  : Packs a stream of bytes into 32-bit words. Four accepted bytes
//             form one word, with the lane order set by LSB_FIRST. The next
//             word keeps assembling while the current output word waits for
//             the downstream side to take it.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    LSB_FIRST  1: first byte -> out_data[7:0];  0: first byte -> out_data[31:24]
//  Ports
//    clk        in   1   clock, all state updates on the rising edge
//    reset      in   1   asynchronous reset, active low
//    in_data    in   8   byte to be packed
//    in_valid   in   1   in_data is valid this cycle
//    in_ready   out  1   block accepts in_data this cycle
//    align      in   1   discard the partial word and restart at byte 0
//    out_data   out  32  assembled word
//    out_valid  out  1   out_data holds a complete word not yet consumed
//    out_ready  in   1   downstream consumes out_data this cycle
//    byte_count out  2   bytes held in the partial word (0..3)
// ============================================================================
module convert8to32 #(
    parameter int LSB_FIRST = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        align,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  byte_count
);

    // Partial word: the three bytes collected before the fourth arrives.
    logic [23:0] partial;
    logic [23:0] partial_next;
    logic [31:0] word_next;
    logic        byte_xfer;
    logic        last_byte;

    // Byte 3 can only be taken when the output register is free, or is being
    // emptied on the same edge. Bytes 0..2 never touch the output register,
    // so they are accepted even under backpressure.
    assign in_ready  = !align && ((byte_count != 2'd3) || !out_valid || out_ready);
    assign byte_xfer = in_valid && in_ready;
    assign last_byte = (byte_count == 2'd3);

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            // Byte 0 sits in partial[7:0]; the new byte becomes the top lane.
            assign word_next = {in_data, partial};

            always_comb begin
                partial_next = partial;
                case (byte_count)
                    2'd0:    partial_next[7:0]   = in_data;
                    2'd1:    partial_next[15:8]  = in_data;
                    2'd2:    partial_next[23:16] = in_data;
                    default: partial_next        = partial;
                endcase
            end
        end else begin : g_msb_first
            // Byte 0 sits in partial[23:16]; the new byte becomes the bottom lane.
            assign word_next = {partial, in_data};

            always_comb begin
                partial_next = partial;
                case (byte_count)
                    2'd0:    partial_next[23:16] = in_data;
                    2'd1:    partial_next[15:8]  = in_data;
                    2'd2:    partial_next[7:0]   = in_data;
                    default: partial_next        = partial;
                endcase
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            partial    <= 24'h0;
            byte_count <= 2'd0;
            out_data   <= 32'h0;
            out_valid  <= 1'b0;
        end else begin
            // Partial-word path. in_ready is low while align is high, so no
            // byte can be accepted on an align edge.
            if (align) begin
                partial    <= 24'h0;
                byte_count <= 2'd0;
            end else if (byte_xfer) begin
                if (last_byte) begin
                    byte_count <= 2'd0;
                end else begin
                    partial    <= partial_next;
                    byte_count <= byte_count + 2'd1;
                end
            end

            // Output register. A completing word takes priority over the
            // consume so back-to-back words keep out_valid high; with
            // out_valid low, clearing it on out_ready is a no-op.
            if (byte_xfer && last_byte) begin
                out_data  <= word_next;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
